// File: rtl/axis_mux_pkg.sv
// Shared types and constants for the two-input AXI-Stream multiplexer.
package axis_mux_pkg;

  localparam int DATA_W = 8;

  localparam logic SEL_S1 = 1'b0;
  localparam logic SEL_S2 = 1'b1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry register slice (main + skid) with a registered input ready.
module axis_skid_buf #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in_beat,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_beat,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] main_r;
  logic [W-1:0] skid_r;
  logic         main_valid_r;
  logic         skid_valid_r;
  logic         ready_r;
  logic         in_fire_s;
  logic         out_fire_s;

  assign in_fire_s  = in_valid && ready_r;
  assign out_fire_s = main_valid_r && out_ready;

  // Main/skid occupancy; ready tracks the next-state emptiness of skid so it never depends on out_ready combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_r       <= '0;
      skid_r       <= '0;
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      ready_r      <= 1'b0;
    end else if (!main_valid_r || out_fire_s) begin
      if (skid_valid_r) begin
        main_r       <= skid_r;
        main_valid_r <= 1'b1;
        skid_valid_r <= 1'b0;
      end else begin
        main_valid_r <= in_fire_s;
        if (in_fire_s) begin
          main_r <= in_beat;
        end
      end
      ready_r <= 1'b1;
    end else if (in_fire_s) begin
      skid_r       <= in_beat;
      skid_valid_r <= 1'b1;
      ready_r      <= 1'b0;
    end else begin
      ready_r <= !skid_valid_r;
    end
  end

  assign in_ready  = ready_r;
  assign out_beat  = main_r;
  assign out_valid = main_valid_r;

endmodule

// File: rtl/axis_mux_2_1.sv
// Two-input AXI-Stream mux with registered skid-buffer output.
// Optional packet-level source locking: define AXIS_MUX_PKT_LOCK_EN.
module axis_mux_2_1
  import axis_mux_pkg::*;
#(
  parameter int DATA_W = axis_mux_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel,
  input  logic [DATA_W-1:0] s_data_1,
  input  logic              s_valid_1,
  output logic              s_ready_1,
  input  logic              s_last_1,
  input  logic [DATA_W-1:0] s_data_2,
  input  logic              s_valid_2,
  output logic              s_ready_2,
  input  logic              s_last_2,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  logic              act_s;
  logic [DATA_W-1:0] in_data_s;
  logic              in_last_s;
  logic              in_valid_s;
  logic              buf_ready_s;
  logic [DATA_W:0]   out_beat_s;

`ifdef AXIS_MUX_PKT_LOCK_EN
  logic act_r;
  logic boundary_r;

  assign act_s = boundary_r ? sel : act_r;

  // Source is re-sampled from sel only between packets.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_r      <= SEL_S1;
      boundary_r <= 1'b1;
    end else begin
      act_r <= act_s;
      if (in_valid_s && buf_ready_s) begin
        boundary_r <= in_last_s;
      end
    end
  end
`else
  assign act_s = sel;
`endif

  // Route the active slave into the buffer; the idle slave is ignored.
  always_comb begin
    in_data_s  = '0;
    in_last_s  = 1'b0;
    in_valid_s = 1'b0;
    case (act_s)
      SEL_S1: begin
        in_data_s  = s_data_1;
        in_last_s  = s_last_1;
        in_valid_s = s_valid_1;
      end
      SEL_S2: begin
        in_data_s  = s_data_2;
        in_last_s  = s_last_2;
        in_valid_s = s_valid_2;
      end
      default: begin
        in_data_s  = '0;
        in_last_s  = 1'b0;
        in_valid_s = 1'b0;
      end
    endcase
  end

  assign s_ready_1 = buf_ready_s && (act_s == SEL_S1);
  assign s_ready_2 = buf_ready_s && (act_s == SEL_S2);

  axis_skid_buf #(
    .W(DATA_W + 1)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .in_beat  ({in_last_s, in_data_s}),
    .in_valid (in_valid_s),
    .in_ready (buf_ready_s),
    .out_beat (out_beat_s),
    .out_valid(m_valid),
    .out_ready(m_ready)
  );

  assign m_data = out_beat_s[DATA_W-1:0];
  assign m_last = out_beat_s[DATA_W];

endmodule

// File: tb/tb_axis_mux_2_1.sv
// Directed self-checking bench for axis_mux_2_1.
module tb_axis_mux_2_1;

  logic       clk = 1'b0;
  logic       reset;
  logic       sel;
  logic [7:0] s_data_1;
  logic       s_valid_1;
  logic       s_ready_1;
  logic       s_last_1;
  logic [7:0] s_data_2;
  logic       s_valid_2;
  logic       s_ready_2;
  logic       s_last_2;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;

  int vectors = 0;
  int miscompares = 0;

  axis_mux_2_1 #(.DATA_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .sel      (sel),
    .s_data_1 (s_data_1),
    .s_valid_1(s_valid_1),
    .s_ready_1(s_ready_1),
    .s_last_1 (s_last_1),
    .s_data_2 (s_data_2),
    .s_valid_2(s_valid_2),
    .s_ready_2(s_ready_2),
    .s_last_2 (s_last_2),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; sel = 1'b0; m_ready = 1'b1;
    s_data_1 = 8'h00; s_valid_1 = 1'b0; s_last_1 = 1'b0;
    s_data_2 = 8'h00; s_valid_2 = 1'b0; s_last_2 = 1'b0;
    tick(); tick();
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'h00);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_s_ready_1", 32'(s_ready_1), 32'd0);
    chk("rst_s_ready_2", 32'(s_ready_2), 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_s_ready_1", 32'(s_ready_1), 32'd1);
    chk("post_rst_s_ready_2", 32'(s_ready_2), 32'd0);
    chk("post_rst_m_valid", 32'(m_valid), 32'd0);

    // streaming
    s_valid_1 = 1'b1; s_data_1 = 8'h11;
    tick();
    chk("stream_valid_11", 32'(m_valid), 32'd1);
    chk("stream_data_11", 32'(m_data), 32'h11);
    s_data_1 = 8'h22;
    tick();
    chk("stream_data_22", 32'(m_data), 32'h22);
    s_data_1 = 8'h33;
    tick();
    chk("stream_data_33", 32'(m_data), 32'h33);
    chk("stream_s_ready_2", 32'(s_ready_2), 32'd0);
    s_valid_1 = 1'b0;
    tick();
    chk("stream_drained", 32'(m_valid), 32'd0);

    // backpressure
    m_ready = 1'b0; s_valid_1 = 1'b1; s_data_1 = 8'h44;
    tick();
    chk("bp_data_44", 32'(m_data), 32'h44);
    chk("bp_ready_hi", 32'(s_ready_1), 32'd1);
    s_data_1 = 8'h55;
    tick();
    chk("bp_hold_1", 32'(m_data), 32'h44);
    chk("bp_ready_lo", 32'(s_ready_1), 32'd0);
    s_data_1 = 8'h66;
    tick();
    chk("bp_hold_2", 32'(m_data), 32'h44);
    chk("bp_ready_lo_2", 32'(s_ready_1), 32'd0);
    tick();
    chk("bp_hold_3", 32'(m_data), 32'h44);
    chk("bp_valid_held", 32'(m_valid), 32'd1);
    m_ready = 1'b1;
    tick();
    chk("bp_drain_55", 32'(m_data), 32'h55);
    chk("bp_ready_back", 32'(s_ready_1), 32'd1);
    tick();
    chk("bp_drain_66", 32'(m_data), 32'h66);
    s_valid_1 = 1'b0;
    tick();
    chk("bp_empty", 32'(m_valid), 32'd0);

    // switch to slave 2
    sel = 1'b1; s_valid_1 = 1'b1; s_data_1 = 8'h77;
    s_valid_2 = 1'b1; s_data_2 = 8'hA5;
    #1;
    chk("sw_s_ready_1", 32'(s_ready_1), 32'd0);
    chk("sw_s_ready_2", 32'(s_ready_2), 32'd1);
    tick();
    chk("sw_data_a5", 32'(m_data), 32'hA5);
    chk("sw_last_a5", 32'(m_last), 32'd0);
    s_data_2 = 8'h3C; s_last_2 = 1'b1;
    tick();
    chk("last_data_3c", 32'(m_data), 32'h3C);
    chk("last_flag_3c", 32'(m_last), 32'd1);
    s_valid_2 = 1'b0; s_last_2 = 1'b0;
    tick();
    chk("sw_s1_not_fwd", 32'(m_valid), 32'd0);
    sel = 1'b0;
    tick();
    chk("back_s1_data_77", 32'(m_data), 32'h77);
    chk("back_s1_last", 32'(m_last), 32'd0);

    // asynchronous reset mid-stream
    m_ready = 1'b0; s_data_1 = 8'h88;
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("arst_m_valid", 32'(m_valid), 32'd0);
    chk("arst_s_ready_1", 32'(s_ready_1), 32'd0);
    chk("arst_s_ready_2", 32'(s_ready_2), 32'd0);
    s_valid_1 = 1'b0;
    tick();
    reset = 1'b0; m_ready = 1'b1;
    tick();
    chk("arst_rel_ready", 32'(s_ready_1), 32'd1);
    chk("arst_no_stale", 32'(m_valid), 32'd0);

`ifdef AXIS_MUX_PKT_LOCK_EN
    s_valid_1 = 1'b1; s_data_1 = 8'h01; s_last_1 = 1'b0;
    tick();
    chk("lock_data_01", 32'(m_data), 32'h01);
    sel = 1'b1; s_valid_2 = 1'b1; s_data_2 = 8'hF0;
    s_data_1 = 8'h02; s_last_1 = 1'b1;
    #1;
    chk("lock_hold_s1", 32'(s_ready_1), 32'd1);
    chk("lock_block_s2", 32'(s_ready_2), 32'd0);
    tick();
    chk("lock_data_02", 32'(m_data), 32'h02);
    chk("lock_last_02", 32'(m_last), 32'd1);
    chk("lock_switch_s2", 32'(s_ready_2), 32'd1);
    tick();
    chk("lock_data_f0", 32'(m_data), 32'hF0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
